// File: rtl/cost_stager.sv
// ============================================================================
// cost_stager
// ----------------------------------------------------------------------------
// Stages an N x N cost matrix for a downstream assignment solver and captures
// the solver's result for a consumer.
//
// Operation:
//   LOAD   : accepts N*N cost beats in row-major order (beat k is the cost of
//            worker k/N doing job k%N) and holds the solver in reset.
//   SERVE  : releases the solver. The solver reads cost[W][J] through the
//            registered Cost port. The first sol_valid seen is captured.
//   REPORT : presents the captured result until the consumer accepts it.
//            The solver is held in reset again and the block then returns to
//            LOAD. The matrix contents are kept until each beat is rewritten.
//
// Ports:
//   CLK            single clock; all state changes on its rising edge
//   RST            asynchronous, active-high reset
//   in_valid       upstream cost beat valid
//   in_ready       block can accept a cost beat (LOAD only)
//   in_data        cost beat, CW bits
//   solver_rst     active-high reset to the solver (low only in SERVE)
//   W, J           solver worker / job read address
//   Cost           cost[W][J], one cycle after the address is presented
//   sol_valid      solver result valid (level)
//   sol_mincost    solver minimum total cost
//   sol_matchcount solver count of minimum-cost assignments
//   res_valid      captured result available
//   res_ready      result consumer accepts
//   res_mincost    captured minimum cost
//   res_matchcount captured match count
// ============================================================================
module cost_stager #(
    parameter int CW = 7,   // cost entry width in bits
    parameter int N  = 8    // matrix dimension; this release supports 8 only
) (
    input  logic          CLK,
    input  logic          RST,
    // cost beat upload
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_data,
    // solver side
    output logic          solver_rst,
    input  logic [2:0]    W,
    input  logic [2:0]    J,
    output logic [CW-1:0] Cost,
    input  logic          sol_valid,
    input  logic [9:0]    sol_mincost,
    input  logic [3:0]    sol_matchcount,
    // result delivery
    output logic          res_valid,
    input  logic          res_ready,
    output logic [9:0]    res_mincost,
    output logic [3:0]    res_matchcount
);

    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_BEAT = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SERVE  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] ld_cnt;
    logic [CW-1:0] mem [DEPTH];

    // in_ready is a registered copy of (state == LOAD), so a beat is taken
    // exactly when the FSM is loading.
    logic          accept;
    logic [AW-1:0] rd_addr;

    assign accept  = in_valid && in_ready;
    // Row-major address: worker selects the row of N entries, job the column.
    assign rd_addr = AW'({W, J});

    // ------------------------------------------------------------------------
    // Control FSM. All handshake outputs are registered and change together
    // with the state, so each output is a clean function of the state.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the values present before the clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= LOAD;
            ld_cnt         <= '0;
            in_ready       <= 1'b1;
            solver_rst     <= 1'b1;
            res_valid      <= 1'b0;
            res_mincost    <= '0;
            res_matchcount <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        // Wraps to zero on the final beat, ready for the next load.
                        ld_cnt <= ld_cnt + AW'(1);
                        if (ld_cnt == LAST_BEAT) begin
                            state      <= SERVE;
                            in_ready   <= 1'b0;
                            solver_rst <= 1'b0;
                        end
                    end
                end

                SERVE: begin
                    // The solver's result only counts once it is out of reset.
                    if (!solver_rst && sol_valid) begin
                        res_mincost    <= sol_mincost;
                        res_matchcount <= sol_matchcount;
                        res_valid      <= 1'b1;
                        solver_rst     <= 1'b1;
                        state          <= REPORT;
                    end
                end

                REPORT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= LOAD;
                    end
                end

                default: begin
                    state      <= LOAD;
                    in_ready   <= 1'b1;
                    solver_rst <= 1'b1;
                    res_valid  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Cost matrix storage. Written only while loading; read-only otherwise.
    // ------------------------------------------------------------------------
    // NOTE: the array is cleared by reset because a reset must discard any
    // partial matrix; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[ld_cnt] <= in_data;
        end
    end

    // Registered read port, active in every state. A write and a read of the
    // same entry on one edge return the previous contents (no bypass).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Cost <= '0;
        end else begin
            Cost <= mem[rd_addr];
        end
    end

endmodule
